// File: rtl/input_conditioner.sv
// Board-pin conditioning for the Nios PIO inputs: two-flop synchronisers, per-key counting
// debouncers with press/release pulses, and a tick-sampled two-agreement switch filter.
module input_conditioner #(
    parameter int NUM_KEYS         = 4,
    parameter int NUM_SW           = 18,
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int SW_SAMPLE_CYCLES = 500000,
    parameter int CNT_W            = 20
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_SW-1:0]   sw_in,
    output logic [NUM_KEYS-1:0] keys_export,
    output logic [NUM_SW-1:0]   switches_export,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                sw_changed
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SW_SAMPLE_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_sync1_r;
    logic [NUM_KEYS-1:0] key_sync2_r;
    logic [NUM_KEYS-1:0] key_level_s;
    logic [CNT_W-1:0]    key_cnt_r     [NUM_KEYS];
    logic [CNT_W-1:0]    key_cnt_nxt_s [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_stable_nxt_s;
    logic [NUM_KEYS-1:0] key_press_nxt_s;
    logic [NUM_KEYS-1:0] key_release_nxt_s;

    logic [NUM_SW-1:0]   sw_sync1_r;
    logic [NUM_SW-1:0]   sw_sync2_r;
    logic [NUM_SW-1:0]   sw_smp_r;
    logic [CNT_W-1:0]    sw_tick_cnt_r;
    logic                sw_tick_s;
    logic                sw_load_s;

    // Raw pins are active-low; internally 1 means pressed.
    assign key_level_s = ~key_sync2_r;

    // Per-key debounce decision: accept a new level only after it has held for the full window.
    always_comb begin
        key_stable_nxt_s  = keys_export;
        key_press_nxt_s   = {NUM_KEYS{1'b0}};
        key_release_nxt_s = {NUM_KEYS{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_cnt_nxt_s[i] = CNT_ZERO;
            if (key_level_s[i] == keys_export[i]) begin
                key_cnt_nxt_s[i] = CNT_ZERO;
            end else if (key_cnt_r[i] == DEB_LAST) begin
                key_cnt_nxt_s[i]     = CNT_ZERO;
                key_stable_nxt_s[i]  = key_level_s[i];
                key_press_nxt_s[i]   = key_level_s[i];
                key_release_nxt_s[i] = ~key_level_s[i];
            end else begin
                key_cnt_nxt_s[i] = key_cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Switch filter: the vector is taken only when two consecutive tick samples agree.
    always_comb begin
        sw_tick_s = (sw_tick_cnt_r == SMP_LAST);
        if (sw_tick_s && (sw_sync2_r == sw_smp_r) && (sw_sync2_r != switches_export)) begin
            sw_load_s = 1'b1;
        end else begin
            sw_load_s = 1'b0;
        end
    end

    // State and registered outputs; reset drops any pending debounce without pulsing.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            key_sync1_r     <= {NUM_KEYS{1'b1}};
            key_sync2_r     <= {NUM_KEYS{1'b1}};
            sw_sync1_r      <= {NUM_SW{1'b0}};
            sw_sync2_r      <= {NUM_SW{1'b0}};
            sw_smp_r        <= {NUM_SW{1'b0}};
            sw_tick_cnt_r   <= CNT_ZERO;
            keys_export     <= {NUM_KEYS{1'b0}};
            key_press       <= {NUM_KEYS{1'b0}};
            key_release     <= {NUM_KEYS{1'b0}};
            switches_export <= {NUM_SW{1'b0}};
            sw_changed      <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            key_sync1_r <= key_n_in;
            key_sync2_r <= key_sync1_r;
            sw_sync1_r  <= sw_in;
            sw_sync2_r  <= sw_sync1_r;
            keys_export <= key_stable_nxt_s;
            key_press   <= key_press_nxt_s;
            key_release <= key_release_nxt_s;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_cnt_r[i] <= key_cnt_nxt_s[i];
            end
            if (sw_tick_s) begin
                sw_tick_cnt_r <= CNT_ZERO;
                sw_smp_r      <= sw_sync2_r;
            end else begin
                sw_tick_cnt_r <= sw_tick_cnt_r + CNT_ONE;
            end
            if (sw_load_s) begin
                switches_export <= sw_sync2_r;
            end
            sw_changed <= sw_load_s;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a window-based reference model predicts every
// cycle's outputs, a negedge monitor compares them, and directed tasks time key/switch events.
module tb_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 18;
    localparam int D  = 4;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          reset_reset;
    logic [NK-1:0] key_n_in;
    logic [NS-1:0] sw_in;
    logic [NK-1:0] keys_export;
    logic [NS-1:0] switches_export;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          sw_changed;

    input_conditioner #(
        .NUM_KEYS(NK), .NUM_SW(NS), .DEBOUNCE_CYCLES(D), .SW_SAMPLE_CYCLES(S), .CNT_W(20)
    ) dut (
        .clk_clk(clk), .reset_reset(reset_reset), .key_n_in(key_n_in), .sw_in(sw_in),
        .keys_export(keys_export), .switches_export(switches_export),
        .key_press(key_press), .key_release(key_release), .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NK-1:0] keys;
        logic [NS-1:0] sw;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic          chg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model state: raw-input history, accepted levels, mismatch windows, edge count.
    logic [NK-1:0] m_kraw1, m_kraw2, m_keys;
    logic [NS-1:0] m_sraw1, m_sraw2, m_smp, m_sw;
    bit            m_hist [NK][D];
    int            m_edges;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // A key level is accepted once D consecutive edges have seen it differ from the accepted level.
    task automatic model_step();
        exp_t          e;
        logic [NK-1:0] kp;
        bit            all_mis;
        e = '0;
        if (reset_reset) begin
            m_kraw1 = '1; m_kraw2 = '1; m_sraw1 = '0; m_sraw2 = '0;
            m_keys = '0; m_sw = '0; m_smp = '0; m_edges = 0;
            for (int i = 0; i < NK; i++)
                for (int j = 0; j < D; j++) m_hist[i][j] = 1'b0;
        end else begin
            kp = ~m_kraw2;
            m_edges++;
            for (int i = 0; i < NK; i++) begin
                for (int j = D - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = (kp[i] != m_keys[i]);
                all_mis = 1'b1;
                for (int j = 0; j < D; j++) all_mis = all_mis & m_hist[i][j];
                if (all_mis) begin
                    m_keys[i]  = kp[i];
                    e.press[i] = kp[i];
                    e.rel[i]   = ~kp[i];
                    for (int j = 0; j < D; j++) m_hist[i][j] = 1'b0;
                end
            end
            if (m_edges % S == 0) begin
                if (m_sraw2 == m_smp && m_sraw2 != m_sw) begin
                    m_sw  = m_sraw2;
                    e.chg = 1'b1;
                end
                m_smp = m_sraw2;
            end
            m_kraw2 = m_kraw1; m_kraw1 = key_n_in;
            m_sraw2 = m_sraw1; m_sraw1 = sw_in;
        end
        e.keys = m_keys;
        e.sw   = m_sw;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: one expected record per clock, compared half a cycle after the edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_keys_export",     32'(keys_export),     32'(e.keys));
            check("sb_switches_export", 32'(switches_export), 32'(e.sw));
            check("sb_key_press",       32'(key_press),       32'(e.press));
            check("sb_key_release",     32'(key_release),     32'(e.rel));
            check("sb_sw_changed",      32'(sw_changed),      32'(e.chg));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Watch key idx for 20 cycles after a drive: when it rises and how many press pulses appear.
    task automatic measure_rise(input int idx, output int k_rise, output int n_press);
        k_rise  = -1;
        n_press = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k_rise < 0 && keys_export[idx]) k_rise = k;
            if (key_press[idx]) n_press++;
        end
    endtask

    initial begin
        int k_rise, n_press, k_rel, k_pr, n_chg, guard, hold;
        reset_reset = 1'b1;
        key_n_in    = 4'b0000;
        sw_in       = 18'h3FFFF;
        repeat (3) @(negedge clk);
        check("reset_keys", 32'(keys_export), 32'h0);
        check("reset_sw",   32'(switches_export), 32'h0);
        reset_reset = 1'b0;
        key_n_in    = 4'b1111;
        sw_in       = 18'h00000;
        @(negedge clk);
        check("post_reset_pulses", 32'({key_press, key_release, sw_changed}), 32'h0);
        repeat (10) @(negedge clk);

        // Single key press latency.
        key_n_in[0] = 1'b0;
        measure_rise(0, k_rise, n_press);
        check("key0_rise_latency", 32'(k_rise), 32'd6);
        check("key0_press_count",  32'(n_press), 32'd1);

        // Bounce on key 2: three low, one high, then steady low.
        key_n_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        key_n_in[2] = 1'b1;
        @(negedge clk);
        check("key2_no_early", 32'(keys_export[2]), 32'h0);
        key_n_in[2] = 1'b0;
        measure_rise(2, k_rise, n_press);
        check("key2_rise_latency", 32'(k_rise), 32'd6);
        check("key2_press_count",  32'(n_press), 32'd1);

        // Simultaneous release of key 0 and press of key 3.
        key_n_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        check("keys_before_swap", 32'(keys_export), 32'h1);
        key_n_in[0] = 1'b1;
        key_n_in[3] = 1'b0;
        k_rel = -1;
        k_pr  = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k_rel < 0 && key_release[0]) k_rel = k;
            if (k_pr < 0 && key_press[3]) k_pr = k;
        end
        check("key0_release_at", 32'(k_rel), 32'd6);
        check("key3_press_at",   32'(k_pr),  32'd6);
        check("keys_after_swap", 32'(keys_export), 32'h8);

        // Switch change accepted once, then a sub-period glitch rejected.
        sw_in = 18'h00005;
        n_chg = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sw_changed) n_chg++;
        end
        check("sw_value",        32'(switches_export), 32'h5);
        check("sw_changed_once", 32'(n_chg), 32'd1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((m_edges % S) != 0 && guard < 3 * S);
        check("tick_align_found", 32'(guard < 3 * S), 32'h1);
        sw_in[1] = 1'b1;
        repeat (5) @(negedge clk);
        sw_in[1] = 1'b0;
        n_chg = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (sw_changed) n_chg++;
        end
        check("sw_glitch_no_pulse", 32'(n_chg), 32'd0);
        check("sw_glitch_value",    32'(switches_export), 32'h5);

        // Reset while key 1's counter is at 2.
        key_n_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        reset_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_reset_key1", 32'(keys_export[1]), 32'h0);
        reset_reset = 1'b0;
        measure_rise(1, k_rise, n_press);
        check("key1_rise_after_reset", 32'(k_rise), 32'd6);
        check("key1_press_after_reset", 32'(n_press), 32'd1);

        // Randomised activity checked by the scoreboard.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 49) == 0) reset_reset = 1'b1;
            else reset_reset = 1'b0;
            if ($urandom_range(0, 1) == 1) key_n_in = key_n_in ^ NK'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) sw_in = NS'($urandom);
            hold = $urandom_range(1, 12);
            repeat (hold) @(negedge clk);
        end
        reset_reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
